// File: rtl/ex_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_operand_stage_pkg
//  Purpose  : Shared encodings for the ID/EX operand stage and the ALU
//             control decoder (operand selects, ALU control codes).
//  Revision : 1.0  initial release
// ============================================================================
package ex_operand_stage_pkg;

  typedef logic [3:0] aluctr_t;
  typedef logic [1:0] bsel_t;

  // Operand A source
  localparam logic ASEL_RS1 = 1'b0;
  localparam logic ASEL_PC  = 1'b1;

  // Operand B source
  localparam bsel_t BSEL_RS2  = 2'd0;
  localparam bsel_t BSEL_IMM  = 2'd1;
  localparam bsel_t BSEL_FOUR = 2'd2;
  localparam bsel_t BSEL_ZERO = 2'd3;

  // ALU control codes (bit 3 selects the SUB/SRA variant)
  localparam aluctr_t ALU_ADD  = 4'b0000;
  localparam aluctr_t ALU_SLL  = 4'b0001;
  localparam aluctr_t ALU_SLT  = 4'b0010;
  localparam aluctr_t ALU_SLTU = 4'b0011;
  localparam aluctr_t ALU_XOR  = 4'b0100;
  localparam aluctr_t ALU_SRL  = 4'b0101;
  localparam aluctr_t ALU_OR   = 4'b0110;
  localparam aluctr_t ALU_AND  = 4'b0111;
  localparam aluctr_t ALU_SUB  = 4'b1000;
  localparam aluctr_t ALU_SRA  = 4'b1101;

  // A bypass source matches register r; x0 is hard-wired and never bypassed.
  function automatic logic fwd_hit(input logic       regwr,
                                   input logic [4:0] rd,
                                   input logic [4:0] r);
    return regwr && (rd != 5'd0) && (rd == r);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_operand_stage_if
//  Purpose  : Decode-side, bypass and EX-side bundle of the ID/EX operand
//             stage. The stage uses the slave view, its environment master.
//  Revision : 1.0  initial release
// ============================================================================
interface ex_operand_stage_if #(
  parameter int XLEN = 32
);
  import ex_operand_stage_pkg::*;

  // Decode side
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  aluctr_t         id_aluctr;
  logic            id_asel;
  bsel_t           id_bsel;
  logic            id_regwr;
  logic            id_memrd;
  logic            id_memwr;

  // Writeback bypass from MEM and WB
  logic            m_regwr;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;
  logic            w_regwr;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_data;

  logic            flush;

  // EX side
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_da;
  logic [XLEN-1:0] ex_db;
  aluctr_t         ex_aluctr;
  logic [XLEN-1:0] ex_store_data;
  logic [4:0]      ex_rd;
  logic            ex_regwr;
  logic            ex_memrd;
  logic            ex_memwr;
  logic [31:0]     stall_cnt;

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_aluctr, id_asel, id_bsel, id_regwr, id_memrd, id_memwr,
           m_regwr, m_rd, m_data, w_regwr, w_rd, w_data, flush, ex_ready,
    output id_ready, ex_valid, ex_da, ex_db, ex_aluctr, ex_store_data, ex_rd,
           ex_regwr, ex_memrd, ex_memwr, stall_cnt
  );

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_aluctr, id_asel, id_bsel, id_regwr, id_memrd, id_memwr,
           m_regwr, m_rd, m_data, w_regwr, w_rd, w_data, flush, ex_ready,
    input  id_ready, ex_valid, ex_da, ex_db, ex_aluctr, ex_store_data, ex_rd,
           ex_regwr, ex_memrd, ex_memwr, stall_cnt
  );

endinterface
`default_nettype wire

// File: rtl/ex_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module   : ex_operand_stage_fwd_mux
//  Purpose  : Per-source-register bypass select: MEM result, else WB result,
//             else register-file data. Pass-through when bypass is disabled.
//  Revision : 1.0  initial release
// ============================================================================
module ex_operand_stage_fwd_mux #(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [4:0]      r,
  input  logic [XLEN-1:0] rf_data,
  input  logic            m_regwr,
  input  logic [4:0]      m_rd,
  input  logic [XLEN-1:0] m_data,
  input  logic            w_regwr,
  input  logic [4:0]      w_rd,
  input  logic [XLEN-1:0] w_data,
  output logic [XLEN-1:0] fwd_data
);
  import ex_operand_stage_pkg::*;

  generate
    if (FWD_EN) begin : g_fwd
      // MEM is younger than WB, so its result wins when both match
      always_comb begin
        fwd_data = rf_data;
        if (fwd_hit(m_regwr, m_rd, r))
          fwd_data = m_data;
        else if (fwd_hit(w_regwr, w_rd, r))
          fwd_data = w_data;
      end
    end else begin : g_nofwd
      logic unused_bypass;
      assign unused_bypass = ^{r, m_regwr, m_rd, m_data, w_regwr, w_rd, w_data};
      assign fwd_data      = rf_data;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_operand_stage
//  Purpose  : ID/EX register in front of the RV32 ALU. Bypasses and selects
//             operands, stalls on load-use, honours flush and backpressure,
//             and counts hazard-stall cycles.
//  Revision : 1.0  initial release
// ============================================================================
module ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  ex_operand_stage_if.slave  bus
);
  import ex_operand_stage_pkg::*;

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] da_sel;
  logic [XLEN-1:0] db_sel;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            hazard;
  logic            accept;

  ex_operand_stage_fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd_rs1 (
    .r(bus.id_rs1), .rf_data(bus.id_rs1_data),
    .m_regwr(bus.m_regwr), .m_rd(bus.m_rd), .m_data(bus.m_data),
    .w_regwr(bus.w_regwr), .w_rd(bus.w_rd), .w_data(bus.w_data),
    .fwd_data(rs1_fwd)
  );

  ex_operand_stage_fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd_rs2 (
    .r(bus.id_rs2), .rf_data(bus.id_rs2_data),
    .m_regwr(bus.m_regwr), .m_rd(bus.m_rd), .m_data(bus.m_data),
    .w_regwr(bus.w_regwr), .w_rd(bus.w_rd), .w_data(bus.w_data),
    .fwd_data(rs2_fwd)
  );

  // Stores read rs2 even when operand B is the immediate.
  assign uses_rs1 = (bus.id_asel == ASEL_RS1);
  assign uses_rs2 = (bus.id_bsel == BSEL_RS2) || bus.id_memwr;

  // A load still in EX has no data to bypass yet; hold the consumer back.
  assign hazard = bus.ex_valid && bus.ex_memrd && (bus.ex_rd != 5'd0) &&
                  ((uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                   (uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

  assign bus.id_ready = (!bus.ex_valid || bus.ex_ready) && !hazard;
  assign accept       = bus.id_valid && bus.id_ready && !bus.flush;

  assign da_sel = (bus.id_asel == ASEL_PC) ? bus.id_pc : rs1_fwd;

  // Operand B source select
  always_comb begin
    db_sel = rs2_fwd;
    case (bus.id_bsel)
      BSEL_RS2:  db_sel = rs2_fwd;
      BSEL_IMM:  db_sel = bus.id_imm;
      BSEL_FOUR: db_sel = XLEN'(32'd4);
      default:   db_sel = '0;
    endcase
  end

  // Output register: flush kills, accept loads, a drained slot empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ex_valid      <= 1'b0;
      bus.ex_da         <= '0;
      bus.ex_db         <= '0;
      bus.ex_aluctr     <= '0;
      bus.ex_store_data <= '0;
      bus.ex_rd         <= '0;
      bus.ex_regwr      <= 1'b0;
      bus.ex_memrd      <= 1'b0;
      bus.ex_memwr      <= 1'b0;
    end else if (bus.flush) begin
      bus.ex_valid <= 1'b0;
    end else if (accept) begin
      bus.ex_valid      <= 1'b1;
      bus.ex_da         <= da_sel;
      bus.ex_db         <= db_sel;
      bus.ex_aluctr     <= bus.id_aluctr;
      bus.ex_store_data <= rs2_fwd;
      bus.ex_rd         <= bus.id_rd;
      bus.ex_regwr      <= bus.id_regwr;
      bus.ex_memrd      <= bus.id_memrd;
      bus.ex_memwr      <= bus.id_memwr;
    end else if (bus.ex_ready) begin
      bus.ex_valid <= 1'b0;
    end
  end

  // Count cycles where a real instruction is held back by a load-use hazard
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.stall_cnt <= '0;
    else if (bus.id_valid && hazard && !bus.flush)
      bus.stall_cnt <= bus.stall_cnt + 32'd1;
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_operand_stage
//  Purpose  : Directed bench for ex_operand_stage with a reference model and
//             a per-cycle output comparison.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_operand_stage_if #(.XLEN(32)) bus ();

  ex_operand_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        mv, m_regwr_q, m_memrd_q, m_memwr_q;
  logic [31:0] m_da, m_db, m_sd, m_stall;
  logic [3:0]  m_alu;
  logic [4:0]  m_rd_q;

  function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] rf);
    if (bus.m_regwr && bus.m_rd != 5'd0 && bus.m_rd == r) return bus.m_data;
    if (bus.w_regwr && bus.w_rd != 5'd0 && bus.w_rd == r) return bus.w_data;
    return rf;
  endfunction

  function automatic logic model_hazard();
    logic reads_a, reads_b;
    reads_a = (bus.id_asel == 1'b0);
    reads_b = (bus.id_bsel == 2'd0) || bus.id_memwr;
    return mv && m_memrd_q && m_rd_q != 5'd0 &&
           ((reads_a && bus.id_rs1 == m_rd_q) || (reads_b && bus.id_rs2 == m_rd_q));
  endfunction

  function automatic logic model_ready();
    return (!mv || bus.ex_ready) && !model_hazard();
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mv = 0; m_regwr_q = 0; m_memrd_q = 0; m_memwr_q = 0;
      m_da = 0; m_db = 0; m_sd = 0; m_stall = 0; m_alu = 0; m_rd_q = 0;
    end else begin
      logic haz, rdy;
      haz = model_hazard();
      rdy = model_ready();
      if (bus.id_valid && haz && !bus.flush) m_stall = m_stall + 1;
      if (bus.flush) mv = 0;
      else if (bus.id_valid && rdy) begin
        mv = 1;
        m_da = bus.id_asel ? bus.id_pc : model_fwd(bus.id_rs1, bus.id_rs1_data);
        case (bus.id_bsel)
          2'd0: m_db = model_fwd(bus.id_rs2, bus.id_rs2_data);
          2'd1: m_db = bus.id_imm;
          2'd2: m_db = 32'd4;
          default: m_db = 32'd0;
        endcase
        m_sd = model_fwd(bus.id_rs2, bus.id_rs2_data);
        m_alu = bus.id_aluctr; m_rd_q = bus.id_rd;
        m_regwr_q = bus.id_regwr; m_memrd_q = bus.id_memrd; m_memwr_q = bus.id_memwr;
      end else if (bus.ex_ready) mv = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("cmp_valid", 32'(bus.ex_valid), 32'(mv));
      check("cmp_ready", 32'(bus.id_ready), 32'(model_ready()));
      check("cmp_da", bus.ex_da, m_da);
      check("cmp_db", bus.ex_db, m_db);
      check("cmp_sd", bus.ex_store_data, m_sd);
      check("cmp_alu", 32'(bus.ex_aluctr), 32'(m_alu));
      check("cmp_rd", 32'(bus.ex_rd), 32'(m_rd_q));
      check("cmp_flags", {29'd0, bus.ex_regwr, bus.ex_memrd, bus.ex_memwr},
            {29'd0, m_regwr_q, m_memrd_q, m_memwr_q});
      check("cmp_stall", bus.stall_cnt, m_stall);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_byp();
    bus.m_regwr = 0; bus.m_rd = 0; bus.m_data = 0;
    bus.w_regwr = 0; bus.w_rd = 0; bus.w_data = 0;
  endtask

  task automatic clear_id();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0;
    bus.id_imm = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_aluctr = ALU_ADD; bus.id_asel = ASEL_RS1; bus.id_bsel = BSEL_RS2;
    bus.id_regwr = 0; bus.id_memrd = 0; bus.id_memwr = 0;
    clear_byp();
  endtask

  task automatic load(input logic [4:0] rd);
    clear_id();
    bus.id_valid = 1; bus.id_rs1 = 5'd2; bus.id_rs1_data = 32'h1000;
    bus.id_bsel = BSEL_IMM; bus.id_imm = 32'h10; bus.id_rd = rd;
    bus.id_regwr = 1; bus.id_memrd = 1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0; errors = 0;
    rst = 1; clear_id(); bus.flush = 0; bus.ex_ready = 1;
    #1;
    check("rst_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_da", bus.ex_da, 32'd0);
    check("rst_stall", bus.stall_cnt, 32'd0);
    step(); rst = 0;

    // ADD after ADD: x5 bypassed from MEM
    clear_id(); bus.id_valid = 1; bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd6;
    bus.id_rs2_data = 32'h22; bus.id_rd = 5'd8; bus.id_regwr = 1;
    bus.m_regwr = 1; bus.m_rd = 5'd5; bus.m_data = 32'h11;
    @(negedge clk); check("add_ready", 32'(bus.id_ready), 32'd1);
    step(); clear_id();
    @(negedge clk);
    check("add_da", bus.ex_da, 32'h11);
    check("add_db", bus.ex_db, 32'h22);
    check("add_valid", 32'(bus.ex_valid), 32'd1);
    step();

    // MEM beats WB on x7
    clear_id(); bus.id_valid = 1; bus.id_rs1 = 5'd1; bus.id_rs1_data = 32'h5;
    bus.id_rs2 = 5'd7; bus.id_rs2_data = 32'h33; bus.id_aluctr = ALU_SUB;
    bus.m_regwr = 1; bus.m_rd = 5'd7; bus.m_data = 32'hA;
    bus.w_regwr = 1; bus.w_rd = 5'd7; bus.w_data = 32'hB;
    step(); clear_id();
    @(negedge clk);
    check("mw_db", bus.ex_db, 32'hA);
    check("mw_sd", bus.ex_store_data, 32'hA);
    check("mw_da", bus.ex_da, 32'h5);
    step();

    // x0 is never bypassed
    clear_id(); bus.id_valid = 1; bus.id_rs2 = 5'd0; bus.id_rs2_data = 32'h33;
    bus.m_regwr = 1; bus.m_rd = 5'd0; bus.m_data = 32'hA;
    bus.w_regwr = 1; bus.w_rd = 5'd0; bus.w_data = 32'hB;
    step(); clear_id();
    @(negedge clk); check("x0_db", bus.ex_db, 32'h33);
    step();

    // Load-use on rs1: one bubble, then WB-bypassed accept
    load(5'd3);
    step();
    clear_id(); bus.id_valid = 1; bus.id_rs1 = 5'd3; bus.id_bsel = BSEL_IMM;
    bus.id_imm = 32'h4; bus.id_rd = 5'd10; bus.id_regwr = 1;
    @(negedge clk);
    check("lu_ready0", 32'(bus.id_ready), 32'd0);
    check("lu_ld_da", bus.ex_da, 32'h1000);
    step();
    bus.w_regwr = 1; bus.w_rd = 5'd3; bus.w_data = 32'h77;
    @(negedge clk);
    check("lu_bubble", 32'(bus.ex_valid), 32'd0);
    check("lu_stall", bus.stall_cnt, 32'd1);
    check("lu_ready1", 32'(bus.id_ready), 32'd1);
    step(); clear_id(); bus.ex_ready = 0;
    @(negedge clk);
    check("lu_da", bus.ex_da, 32'h77);
    check("lu_db", bus.ex_db, 32'h4);

    // Backpressure: held for 3 cycles with a waiting instruction
    step();
    clear_id(); bus.id_valid = 1; bus.id_pc = 32'h200; bus.id_asel = ASEL_PC;
    bus.id_bsel = BSEL_ZERO; bus.id_rd = 5'd11; bus.id_regwr = 1; bus.id_aluctr = ALU_OR;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", 32'(bus.id_ready), 32'd0);
      check("bp_da", bus.ex_da, 32'h77);
      check("bp_stall", bus.stall_cnt, 32'd1);
      step();
    end
    bus.ex_ready = 1;
    @(negedge clk); check("bp_release", 32'(bus.id_ready), 32'd1);
    step();

    // Flush with a valid EX slot and a valid incoming instruction
    bus.id_pc = 32'h300; bus.id_bsel = BSEL_FOUR; bus.flush = 1;
    @(negedge clk);
    check("fl_pre_da", bus.ex_da, 32'h200);
    check("fl_pre_valid", 32'(bus.ex_valid), 32'd1);
    step(); bus.flush = 0; clear_id();
    @(negedge clk);
    check("fl_valid", 32'(bus.ex_valid), 32'd0);
    check("fl_hold_da", bus.ex_da, 32'h200);
    step();

    // JAL link operands
    clear_id(); bus.id_valid = 1; bus.id_pc = 32'h100; bus.id_asel = ASEL_PC;
    bus.id_bsel = BSEL_FOUR; bus.id_rd = 5'd1; bus.id_regwr = 1;
    step(); clear_id();
    @(negedge clk);
    check("jal_da", bus.ex_da, 32'h100);
    check("jal_db", bus.ex_db, 32'h4);
    step();

    // Store whose rs2 is a pending load result (bsel = imm)
    load(5'd9);
    step();
    clear_id(); bus.id_valid = 1; bus.id_rs1 = 5'd1; bus.id_rs1_data = 32'h500;
    bus.id_rs2 = 5'd9; bus.id_bsel = BSEL_IMM; bus.id_imm = 32'h8; bus.id_memwr = 1;
    @(negedge clk); check("st_ready0", 32'(bus.id_ready), 32'd0);
    step();
    bus.w_regwr = 1; bus.w_rd = 5'd9; bus.w_data = 32'hCAFE;
    @(negedge clk); check("st_stall", bus.stall_cnt, 32'd2);
    step(); clear_id();
    @(negedge clk);
    check("st_sd", bus.ex_store_data, 32'hCAFE);
    check("st_db", bus.ex_db, 32'h8);
    check("st_memwr", 32'(bus.ex_memwr), 32'd1);
    step();

    // Reset during a backpressured load-use stall
    load(5'd4);
    step();
    clear_id(); bus.ex_ready = 0; bus.id_valid = 1; bus.id_rs1 = 5'd4;
    step(); step();
    @(negedge clk);
    check("mr_stall", bus.stall_cnt, 32'd4);
    check("mr_rd", 32'(bus.ex_rd), 32'd4);
    #2 rst = 1;
    #1;
    check("mr_valid0", 32'(bus.ex_valid), 32'd0);
    check("mr_da0", bus.ex_da, 32'd0);
    check("mr_rd0", 32'(bus.ex_rd), 32'd0);
    check("mr_memrd0", 32'(bus.ex_memrd), 32'd0);
    check("mr_stall0", bus.stall_cnt, 32'd0);
    step(); step();
    rst = 0; clear_id(); bus.ex_ready = 1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the RV32 ALU.
- Selects and forwards operands, then registers da, db and aluctr for the ALU, along with the side-band fields that travel with the instruction.
- Uses a valid/ready handshake on both sides, detects load-use hazards and inserts bubbles, and supports a synchronous flush for branch redirect.
- Keeps a stall performance counter.

Parameters:
- XLEN, 32: datapath width.
- FWD_EN, 1: 1 enables M/W bypass; 0 always selects register-file data.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode has an instruction.
- id_ready  out  1  stage accepts this cycle.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_aluctr  in  4  ALU control code, passed through unchanged.
- id_asel  in  1  0 = rs1, 1 = pc.
- id_bsel  in  2  0 = rs2, 1 = imm, 2 = constant 4, 3 = zero.
- id_regwr, id_memrd, id_memwr  in  1  writeback / load / store flags.
- m_regwr, m_rd, m_data  in  1/5/XLEN  MEM-stage writeback bypass.
- w_regwr, w_rd, w_data  in  1/5/XLEN  WB-stage writeback bypass.
- flush  in  1  kill the registered and incoming instruction.
- ex_valid  out  1  output register holds a valid instruction.
- ex_ready  in  1  ALU/EX consumer accepts.
- ex_da, ex_db  out  XLEN  ALU operands.
- ex_aluctr  out  4  ALU control.
- ex_store_data  out  XLEN  forwarded rs2 value for stores.
- ex_rd, ex_regwr, ex_memrd, ex_memwr  out  5/1/1/1  passed-through fields.
- stall_cnt  out  32  count of hazard-stall cycles.

Behaviour:
- Reset (async) drives every output register to 0: ex_valid, ex_da, ex_db, ex_aluctr, ex_store_data, ex_rd, all flags, stall_cnt.
- Latency: 1 cycle. An instruction accepted at edge N is visible on ex_* after edge N.
- uses_rs1 = (id_asel == 0). uses_rs2 = (id_bsel == 0) || id_memwr.
- hazard = ex_valid && ex_memrd && ex_rd != 0 && ((uses_rs1 && id_rs1 == ex_rd) || (uses_rs2 && id_rs2 == ex_rd)).
- id_ready = (!ex_valid || ex_ready) && !hazard. The signal is combinational and never depends on id_valid.
- Accept = id_valid && id_ready. On accept, all ex_* fields load and ex_valid <= 1.
- No accept and ex_ready && ex_valid: ex_valid <= 0 (bubble). Payload fields hold their values.
- No accept and !ex_ready: everything holds. Payload must stay stable while ex_valid && !ex_ready.
- Forwarding per source register r (applies when FWD_EN = 1):
  - m_data if m_regwr && m_rd != 0 && m_rd == r;
  - else w_data if w_regwr && w_rd != 0 && w_rd == r;
  - else register-file data.
  - M has priority over W. x0 is never forwarded.
- Operand select:
  - da = forwarded rs1 or id_pc.
  - db = forwarded rs2 / id_imm / 4 / 0.
  - ex_store_data = forwarded rs2 regardless of bsel.
- flush (synchronous, highest priority): ex_valid <= 0 and no accept happens. id_ready is still computed normally; decode drops its own instruction on flush.
- Flush while stalled: the bubble is inserted and the hazard clears next cycle.
- stall_cnt increments by 1 each cycle with id_valid && hazard && !flush. It wraps at 2^32-1 to 0.
- Reset mid-transfer discards the held instruction; no partial outputs remain.

Decomposition:
- Shared package holds:
  - the ASEL_RS1/ASEL_PC constants;
  - the BSEL_RS2/BSEL_IMM/BSEL_FOUR/BSEL_ZERO constants;
  - the 4-bit ALU control code constants, shared with the ALU's control decoder.
- One natural sub-module: fwd_mux (r index, rf data, m/w bypass in, forwarded data out), instantiated twice.

Test Plan:
- ADD after ADD: M stage writes x5 = 0x11, incoming rs1 = x5, rf = 0x0 -> ex_da = 0x11 one cycle later.
- M and W both write x7 (M 0xA, W 0xB), incoming rs2 = x7, bsel = 0 -> ex_db = 0xA. Same case with rd = x0 -> rf data is used.
- Load-use: LW x3 in EX, next instruction uses x3 as rs1 -> id_ready = 0 for exactly 1 cycle, a bubble is inserted, stall_cnt goes 0 -> 1. Next cycle the instruction is accepted with W-bypassed data.
- Backpressure: ex_ready = 0 for 3 cycles with id_valid = 1 -> ex_* stable, id_ready = 0, stall_cnt unchanged.
- flush asserted while ex_valid = 1 and id_valid = 1 -> ex_valid = 0 next cycle.
- Reset asserted mid-stall -> all outputs 0 immediately, without waiting for a clock edge.
- JAL link: asel = 1, bsel = 2, pc = 0x100 -> ex_da = 0x100, ex_db = 4.
